// File: rtl/exec_result_stage_if.sv
// Bundle of the execute-result handshake and data signals.
// The master modport drives the execute result and pipeline controls and
// receives the registered result. The slave modport belongs to exec_result_stage.
interface exec_result_stage_if #(
  parameter int DATA_W = 16
);
  logic              valid_in;
  logic [2:0]        op;
  logic [DATA_W-1:0] sum_in;
  logic              a_msb;
  logic              b_msb;
  logic              stall;
  logic              flush;
  logic [DATA_W-1:0] result_out;
  logic              valid_out;
  logic [2:0]        flags_out;

  modport master (
    output valid_in, op, sum_in, a_msb, b_msb, stall, flush,
    input  result_out, valid_out, flags_out
  );

  modport slave (
    input  valid_in, op, sum_in, a_msb, b_msb, stall, flush,
    output result_out, valid_out, flags_out
  );
endinterface

// File: rtl/exec_result_stage.sv
// exec_result_stage: registers the execute result and maintains {Z,V,N} flags.
// Signed overflow is detected for ADD/SUB. When EXEC_RESULT_SAT_EN is defined,
// an overflowing result is clamped to the most positive or most negative value.
// Otherwise the wrapped sum passes through and V is still reported.
// Flush takes priority over stall. A stall freezes every output.
module exec_result_stage #(
  parameter int DATA_W = 16
) (
  input logic                clk,
  input logic                rst_n,
  exec_result_stage_if.slave bus
);

  localparam logic [2:0] OP_ADD   = 3'b000;
  localparam logic [2:0] OP_SUB   = 3'b001;
  localparam logic [2:0] OP_XOR   = 3'b010;
  localparam logic [2:0] OP_SHIFT = 3'b100;

  logic              accept;
  logic              ovf;
  logic [DATA_W-1:0] res;
  logic              upd_all;
  logic              upd_z;

  logic [DATA_W-1:0] result_q, result_d;
  logic              valid_q,  valid_d;
  logic              z_q, z_d;
  logic              v_q, v_d;
  logic              n_q, n_d;

  // Decode acceptance and overflow, and form the post-saturation result.
  always_comb begin
    accept = bus.valid_in & ~bus.stall & ~bus.flush;
    ovf    = ~bus.op[2] & ~bus.op[1] & (bus.a_msb == bus.b_msb) &
             (bus.sum_in[DATA_W-1] != bus.a_msb);
`ifdef EXEC_RESULT_SAT_EN
    if (ovf) begin
      res = bus.a_msb ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    end else begin
      res = bus.sum_in;
    end
`else
    res = bus.sum_in;
`endif
    upd_all = accept & ((bus.op == OP_ADD) | (bus.op == OP_SUB));
    upd_z   = accept & ((bus.op == OP_XOR) | (bus.op == OP_SHIFT));
  end

  // Next-state selection: flush clears valid, stall holds, accept loads.
  always_comb begin
    result_d = result_q;
    valid_d  = valid_q;
    z_d      = z_q;
    v_d      = v_q;
    n_d      = n_q;
    if (bus.flush) begin
      valid_d = 1'b0;
    end else if (!bus.stall) begin
      valid_d = bus.valid_in;
      if (accept) begin
        result_d = res;
      end
      if (upd_all | upd_z) begin
        z_d = (res == '0);
      end
      if (upd_all) begin
        v_d = ovf;
        n_d = res[DATA_W-1];
      end
    end
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= '0;
      valid_q  <= 1'b0;
      z_q      <= 1'b0;
      v_q      <= 1'b0;
      n_q      <= 1'b0;
    end else begin
      result_q <= result_d;
      valid_q  <= valid_d;
      z_q      <= z_d;
      v_q      <= v_d;
      n_q      <= n_d;
    end
  end

  assign bus.result_out = result_q;
  assign bus.valid_out  = valid_q;
  assign bus.flags_out  = {z_q, v_q, n_q};

endmodule

// File: tb/tb_exec_result_stage.sv
// Self-checking bench for exec_result_stage (table of directed vectors plus
// hand-written stall/flush, flag-preset and asynchronous-reset sequences).
// Expectations follow EXEC_RESULT_SAT_EN when it is defined.
module tb_exec_result_stage;

  localparam logic [2:0] ADD = 3'b000, SUB = 3'b001, XOR = 3'b010, RED = 3'b011;
  localparam logic [2:0] SHF = 3'b100, PAD = 3'b101, LDB = 3'b110, NOF = 3'b111;

`ifdef EXEC_RESULT_SAT_EN
  localparam logic [15:0] R2 = 16'h7FFF;
  localparam logic [2:0]  F2 = 3'b010;
  localparam logic [15:0] R5 = 16'h8000;
  localparam logic [2:0]  F5 = 3'b011;
  localparam logic [2:0]  F6 = 3'b111;
  localparam logic [2:0]  F8 = 3'b011;
`else
  localparam logic [15:0] R2 = 16'h9000;
  localparam logic [2:0]  F2 = 3'b011;
  localparam logic [15:0] R5 = 16'h7000;
  localparam logic [2:0]  F5 = 3'b010;
  localparam logic [2:0]  F6 = 3'b110;
  localparam logic [2:0]  F8 = 3'b010;
`endif

  typedef struct {
    logic        valid;
    logic [2:0]  op;
    logic [15:0] sum;
    logic        a;
    logic        b;
    logic        stall;
    logic        flush;
    logic        exp_valid;
    logic [15:0] exp_res;
    logic [2:0]  exp_flags;
  } vec_t;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;
  vec_t vecs [17];

  exec_result_stage_if #(.DATA_W(16)) bus ();

  exec_result_stage #(.DATA_W(16)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic v, input logic [2:0] op, input logic [15:0] s,
                              input logic a, input logic b, input logic st, input logic fl,
                              input logic ev, input logic [15:0] er, input logic [2:0] ef);
    vec_t t;
    t.valid = v; t.op = op; t.sum = s; t.a = a; t.b = b; t.stall = st; t.flush = fl;
    t.exp_valid = ev; t.exp_res = er; t.exp_flags = ef;
    return t;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_all(input string name, input logic ev, input logic [15:0] er,
                           input logic [2:0] ef);
    check({name, ".valid"}, {15'd0, bus.valid_out}, {15'd0, ev});
    check({name, ".result"}, bus.result_out, er);
    check({name, ".flags"}, {13'd0, bus.flags_out}, {13'd0, ef});
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input logic [15:0] s,
                       input logic a, input logic b, input logic st, input logic fl);
    bus.valid_in = v; bus.op = op; bus.sum_in = s;
    bus.a_msb = a; bus.b_msb = b; bus.stall = st; bus.flush = fl;
  endtask

  // Drive one cycle of stimulus, let it clock in, then sample 1 time unit later.
  task automatic step(input string name, input logic v, input logic [2:0] op, input logic [15:0] s,
                      input logic a, input logic b, input logic st, input logic fl,
                      input logic ev, input logic [15:0] er, input logic [2:0] ef);
    drive(v, op, s, a, b, st, fl);
    @(posedge clk);
    #1;
    $display("[TB] %s v=%0b op=%0d sum=%h st=%0b fl=%0b -> valid=%0b res=%h flags=%b",
             name, v, op, s, st, fl, bus.valid_out, bus.result_out, bus.flags_out);
    check_all(name, ev, er, ef);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b1;
    drive(1'b0, ADD, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);

    //            v    op   sum        a     b     st    fl    ev    res        flags
    vecs[0]  = mk(1'b1, ADD, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h1234, 3'b000);
    vecs[1]  = mk(1'b1, ADD, 16'h9000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, R2,       F2);
    vecs[2]  = mk(1'b1, SUB, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0000, 3'b100);
    vecs[3]  = mk(1'b1, ADD, 16'h8001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h8001, 3'b001);
    vecs[4]  = mk(1'b1, ADD, 16'h7000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, R5,       F5);
    vecs[5]  = mk(1'b1, XOR, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, F6);
    vecs[6]  = mk(1'b1, NOF, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h1234, F6);
    vecs[7]  = mk(1'b1, SHF, 16'h0010, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0010, F8);
    vecs[8]  = mk(1'b1, RED, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, F8);
    vecs[9]  = mk(1'b1, PAD, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'hFFFF, F8);
    vecs[10] = mk(1'b1, LDB, 16'h00AB, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h00AB, F8);
    vecs[11] = mk(1'b0, ADD, 16'h5555, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h00AB, F8);
    vecs[12] = mk(1'b1, XOR, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h00AB, F8);
    vecs[13] = mk(1'b1, ADD, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h00AB, F8);
    vecs[14] = mk(1'b1, ADD, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 3'b100);
    vecs[15] = mk(1'b1, XOR, 16'h0003, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0000, 3'b100);
    vecs[16] = mk(1'b1, SUB, 16'hFFFF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'hFFFF, 3'b001);

    // Reset: outputs clear asynchronously and stay clear across a clock edge.
    #2 rst_n = 1'b0;
    #1 check_all("reset_async", 1'b0, 16'h0000, 3'b000);
    @(posedge clk);
    #1 check_all("reset_held", 1'b0, 16'h0000, 3'b000);
    #2 rst_n = 1'b1;

    // Table vectors; vecs[0] is taken on the first edge after reset release.
    for (int i = 0; i < 17; i++) begin
      step($sformatf("vec%0d", i), vecs[i].valid, vecs[i].op, vecs[i].sum, vecs[i].a,
           vecs[i].b, vecs[i].stall, vecs[i].flush,
           vecs[i].exp_valid, vecs[i].exp_res, vecs[i].exp_flags);
    end

    // Preset flags to 011, then XOR zero sets Z, then NOFLAG leaves flags alone.
`ifdef EXEC_RESULT_SAT_EN
    step("preset", 1'b1, ADD, 16'h7000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'h8000, 3'b011);
`else
    step("preset", 1'b1, ADD, 16'h8000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h8000, 3'b011);
`endif
    step("xor_z", 1'b1, XOR, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 3'b111);
    step("noflag", 1'b1, NOF, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h1234, 3'b111);

    // ADD accepted, three stalled cycles with a pending Z-setting ADD, then stall+flush.
    step("pre_stall", 1'b1, ADD, 16'h0042, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0042, 3'b000);
    for (int k = 0; k < 3; k++) begin
      step($sformatf("stall%0d", k), 1'b1, ADD, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0,
           1'b1, 16'h0042, 3'b000);
    end
    step("stall_flush", 1'b1, ADD, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0042, 3'b000);

    // Mid-cycle asynchronous reset while valid_out is high, then first accept after release.
    step("pre_reset", 1'b1, ADD, 16'h8001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h8001, 3'b001);
    drive(1'b1, SUB, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    $display("[TB] mid_reset -> valid=%0b res=%h flags=%b",
             bus.valid_out, bus.result_out, bus.flags_out);
    check_all("mid_reset", 1'b0, 16'h0000, 3'b000);
    #1 rst_n = 1'b1;
    step("post_reset", 1'b1, ADD, 16'h0005, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0005, 3'b000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
